// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC generation, one outstanding imem read,
// small prefetch FIFO toward decode, and redirect flush with stale-response discard.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            outstanding;
  logic            discard;

  logic [XLEN-1:0] mem_data [DEPTH];
  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic            accept;
  logic            resp;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count_nxt;
  logic [AW-1:0]   rd_nxt;
  logic [XLEN-1:0] head_data_nxt;
  logic [XLEN-1:0] head_pc_nxt;

  // The outstanding slot is counted against capacity, so a push never finds the FIFO full.
  assign imem_req  = !rst && !outstanding && (count < CW'(DEPTH)) && !redirect_valid;
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_ready;
  assign resp      = imem_rvalid && outstanding;
  assign push      = resp && !discard && !redirect_valid;
  assign pop       = (count != '0) && inst_ready && !redirect_valid;

  // Next occupancy and the value the head register should show after this edge.
  always_comb begin
    count_nxt     = count;
    rd_nxt        = rd_ptr;
    head_data_nxt = inst_data;
    head_pc_nxt   = inst_pc;
    if (pop) begin
      count_nxt = count_nxt - CW'(1);
      rd_nxt    = rd_ptr + AW'(1);
    end
    if (push) begin
      count_nxt = count_nxt + CW'(1);
    end
    if (count_nxt != '0) begin
      if (count == CW'(pop)) begin
        head_data_nxt = imem_rdata;
        head_pc_nxt   = req_pc;
      end else begin
        head_data_nxt = mem_data[rd_nxt];
        head_pc_nxt   = mem_pc[rd_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      inst_valid  <= 1'b0;
      inst_data   <= '0;
      inst_pc     <= '0;
    end else if (redirect_valid) begin
      // A response landing this cycle is dropped; otherwise the in-flight one is marked stale.
      fetch_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
      outstanding <= outstanding && !imem_rvalid;
      discard     <= outstanding && !imem_rvalid;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      inst_valid  <= 1'b0;
      inst_data   <= '0;
      inst_pc     <= '0;
    end else begin
      if (accept) begin
        outstanding <= 1'b1;
        req_pc      <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end
      if (resp) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr     <= rd_nxt;
      count      <= count_nxt;
      inst_valid <= (count_nxt != '0);
      inst_data  <= head_data_nxt;
      inst_pc    <= head_pc_nxt;
    end
  end

  // FIFO storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_data[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]   <= req_pc;
    end
  end

endmodule
